// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache line-fill controller
package cache_pkg;

    localparam int              WORDS_PER_BLOCK  = 8;
    localparam int              WORD_IDX_W       = 3;
    localparam int              ADDR_W           = 16;
    localparam logic [ADDR_W-1:0] LINE_OFFSET_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fill_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/fill_arbiter.sv
// rtl/fill_arbiter.sv - I/D miss grant decision; FILL_RR_ARB_EN selects round-robin on ties
module fill_arbiter
    import cache_pkg::*;
(
`ifdef FILL_RR_ARB_EN
    input  logic clk,
    input  logic rst,
    input  logic accept_i,
`endif
    input  logic i_miss_i,
    input  logic d_miss_i,
    output logic grant_o
);

`ifdef FILL_RR_ARB_EN
    grant_e last_q, last_d;

    always_comb begin
        grant_o = d_miss_i ? GNT_D : GNT_I;
        // On a tie the port that was not served last wins; last starts at I so D takes the first tie.
        if (i_miss_i && d_miss_i) begin
            grant_o = (last_q == GNT_I) ? GNT_D : GNT_I;
        end
        last_d = accept_i ? grant_e'(grant_o) : last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= GNT_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant_o = d_miss_i ? GNT_D : GNT_I;
    end
`endif

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - shared I/D cache line-fill sequencer with pipeline stalls
// Optional build macro: FILL_RR_ARB_EN (round-robin arbitration between I and D misses)
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  d_miss,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [ADDR_W-1:0]     mem_data_in,
    input  logic                  mem_valid,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [ADDR_W-1:0]     fill_addr,
    output logic [ADDR_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] word_num,
    output logic                  i_write_data,
    output logic                  i_write_tag,
    output logic                  d_write_data,
    output logic                  d_write_tag,
    output logic                  i_stall,
    output logic                  d_stall,
    output logic                  busy
);

    fill_state_e           state_q, state_d;
    grant_e                grant_q, grant_d;
    logic [WORD_IDX_W:0]   issue_cnt_q, issue_cnt_d;
    logic [WORD_IDX_W-1:0] recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  arb_grant;
    logic                  accept;
    logic                  write_data;
    logic                  write_tag;

    assign accept = (state_q == IDLE) && (i_miss || d_miss);

    fill_arbiter u_arb (
`ifdef FILL_RR_ARB_EN
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept),
`endif
        .i_miss_i (i_miss),
        .d_miss_i (d_miss),
        .grant_o  (arb_grant)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;
        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_addr   = '0;
        word_num    = '0;
        write_data  = 1'b0;
        write_tag   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d     = grant_e'(arb_grant);
                    base_d      = ((arb_grant == GNT_D) ? d_addr : i_addr) & LINE_OFFSET_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // Requests and returns run independently: memory is pipelined and returns in order.
                if (issue_cnt_q < (WORD_IDX_W+1)'(WORDS_PER_BLOCK)) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_q + {12'b0, issue_cnt_q[WORD_IDX_W-1:0], 1'b0};
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (mem_valid) begin
                    write_data = 1'b1;
                    word_num   = recv_cnt_q;
                    fill_addr  = base_q | {12'b0, recv_cnt_q, 1'b0};
                    recv_cnt_d = recv_cnt_q + 1'b1;
                    if (recv_cnt_q == WORD_IDX_W'(WORDS_PER_BLOCK - 1)) begin
                        state_d = TAG;
                    end
                end
            end
            TAG: begin
                write_tag   = 1'b1;
                fill_addr   = base_q;
                issue_cnt_d = '0;
                recv_cnt_d  = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= GNT_D;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

    assign i_write_data = write_data && (grant_q == GNT_I);
    assign i_write_tag  = write_tag  && (grant_q == GNT_I);
    assign d_write_data = write_data && (grant_q == GNT_D);
    assign d_write_tag  = write_tag  && (grant_q == GNT_D);
    // Stalls mirror the miss lines so a waiting requester stays frozen through the other port's fill.
    assign i_stall      = i_miss && rst;
    assign d_stall      = d_miss && rst;
    assign fill_data    = mem_data_in;
    assign busy         = (state_q != IDLE);

endmodule
